// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one instruction-memory request at a time and
// hands completed fetches to the IF/ID register as {valid, pc, instr}.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          W        = 65
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_write,
    input  logic          flush,
    input  logic [31:0]   br_target,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic [W-1:0]  if_id_d,
    output logic          if_id_write
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [64:0]  pkt_q, pkt_d;
    logic         drop_q, drop_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            pkt_q   <= 65'h0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pkt_d   = pkt_q;
        drop_d  = drop_q;
        if (flush) begin
            pc_d      = {br_target[31:2], 2'b00};
            pkt_d[64] = 1'b0;
            state_d   = S_REQ;
            // A response still owed by memory must be swallowed after a redirect,
            // including one whose request is being accepted on this very edge.
            unique case (state_q)
                S_WAIT:  drop_d = ~imem_rvalid;
                S_REQ:   drop_d = drop_q ? ~imem_rvalid : imem_ready;
                default: drop_d = 1'b0;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (drop_q) begin
                        if (imem_rvalid) drop_d = 1'b0;
                    end else if (imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pkt_d   = {1'b1, pc_q, imem_rdata};
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (pc_write) begin
                        pkt_d[64] = 1'b0;
                        state_d   = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    assign imem_req    = (state_q == S_REQ) && !drop_q;
    assign imem_addr   = pc_q;
    assign if_id_d     = pkt_q;
    assign if_id_write = (pkt_q[64] & pc_write) | flush;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: walks reset, fetch, stall, flush, drop, wrap and
// mid-request reset scenarios with hand-computed expectations.
module tb_if_stage;

    logic          clk;
    logic          rst;
    logic          pc_write;
    logic          flush;
    logic [31:0]   br_target;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic [64:0]   if_id_d;
    logic          if_id_write;

    int vectors;
    int miscompares;

    if_stage #(.RESET_PC(32'h0000_0000), .W(65)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_write    (pc_write),
        .flush       (flush),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_d     (if_id_d),
        .if_id_write (if_id_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [64:0] held;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        pc_write    = 1'b1;
        flush       = 1'b0;
        br_target   = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // Reset held
        tick();
        tick();
        #1;
        checkOutput("rst_pkt", if_id_d, 65'h0);
        checkOutput("rst_write", if_id_write, 1'b0);

        // First fetch out of reset
        rst        = 1'b0;
        imem_ready = 1'b1;
        #1;
        checkOutput("boot_req", imem_req, 1'b1);
        checkOutput("boot_addr", imem_addr, 32'h0);
        checkOutput("boot_write", if_id_write, 1'b0);
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        #1;
        checkOutput("wait_noreq", imem_req, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        checkOutput("first_pkt", if_id_d, {1'b1, 32'h0, 32'h0000_0013});
        checkOutput("first_write", if_id_write, 1'b1);
        checkOutput("full_noreq", imem_req, 1'b0);
        tick();
        checkOutput("next_addr", imem_addr, 32'h4);
        checkOutput("next_req", imem_req, 1'b1);
        checkOutput("consumed_write", if_id_write, 1'b0);

        // Stall in FULL for five cycles
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hAABB_CCDD;
        tick();
        imem_rvalid = 1'b0;
        pc_write    = 1'b0;
        held        = {1'b1, 32'h4, 32'hAABB_CCDD};
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_pkt", if_id_d, held);
            checkOutput("stall_req", imem_req, 1'b0);
            checkOutput("stall_write", if_id_write, 1'b0);
            tick();
        end
        pc_write = 1'b1;
        #1;
        checkOutput("release_write", if_id_write, 1'b1);
        tick();
        checkOutput("release_addr", imem_addr, 32'h8);
        checkOutput("release_req", imem_req, 1'b1);
        checkOutput("release_once", if_id_write, 1'b0);

        // Flush in FULL
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        flush       = 1'b1;
        br_target   = 32'h0000_0103;
        #1;
        checkOutput("flush_write", if_id_write, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_bubble", if_id_d, {1'b0, 32'h8, 32'h1111_1111});
        checkOutput("flush_addr", imem_addr, 32'h100);
        checkOutput("flush_req", imem_req, 1'b1);

        // Flush in WAIT, then a late response that must be dropped
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        flush      = 1'b1;
        br_target  = 32'h0000_0200;
        #1;
        checkOutput("wflush_write", if_id_write, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("drop_noreq0", imem_req, 1'b0);
        tick();
        checkOutput("drop_noreq1", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        checkOutput("late_nowrite", if_id_write, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        checkOutput("late_pkt", if_id_d, {1'b0, 32'h8, 32'h1111_1111});
        checkOutput("drop_req", imem_req, 1'b1);
        checkOutput("drop_addr", imem_addr, 32'h200);

        // PC wrap at the top of the address space
        flush     = 1'b1;
        br_target = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0;
        #1;
        checkOutput("wrap_start", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checkOutput("wrap_pkt", if_id_d, {1'b1, 32'hFFFF_FFFC, 32'h0000_0033});
        tick();
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_req", imem_req, 1'b1);

        // Flush coincident with the response: discarded, no drop pending
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0055;
        flush       = 1'b1;
        br_target   = 32'h0000_0040;
        tick();
        imem_rvalid = 1'b0;
        flush       = 1'b0;
        #1;
        checkOutput("coinc_pkt", if_id_d, {1'b0, 32'hFFFF_FFFC, 32'h0000_0033});
        checkOutput("coinc_req", imem_req, 1'b1);
        checkOutput("coinc_addr", imem_addr, 32'h40);

        // Asynchronous reset in the middle of WAIT
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #1;
        checkOutput("prerst_noreq", imem_req, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_req", imem_req, 1'b1);
        checkOutput("arst_addr", imem_addr, 32'h0);
        checkOutput("arst_pkt", if_id_d, 65'h0);
        checkOutput("arst_write", if_id_write, 1'b0);
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0077;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checkOutput("stale_pkt", if_id_d, 65'h0);
        checkOutput("stale_req", imem_req, 1'b1);
        checkOutput("stale_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0099;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checkOutput("restart_pkt", if_id_d, {1'b1, 32'h0, 32'h0000_0099});
        checkOutput("restart_write", if_id_write, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter W, default 65, SHALL be the packet width; the block SHALL only support W=65.
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port pc_write  input  1  SHALL be the hazard-unit enable; 0 SHALL stall the stage.
REQ-006 Port flush  input  1  SHALL request a redirect to br_target.
REQ-007 Port br_target  input  32  SHALL be the redirect address.
REQ-008 Port imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-009 Port imem_addr  output  32  SHALL be the request address.
REQ-010 Port imem_ready  input  1  SHALL signal that memory accepts a request this cycle.
REQ-011 Port imem_rvalid  input  1  SHALL signal that imem_rdata is valid.
REQ-012 Port imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-013 Port if_id_d  output  W  SHALL be the IF/ID packet {valid[64], pc[63:32], instr[31:0]}.
REQ-014 Port if_id_write  output  1  SHALL be the capture enable for the IF/ID register.

Function
REQ-015 The block SHALL hold a 32-bit pc, a packet buffer pkt[64:0], and a 2-bit FSM with states REQ, WAIT and FULL.
REQ-016 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL be 0 in WAIT and FULL.
REQ-017 On REQ with imem_ready=1, the FSM SHALL move to WAIT; otherwise it SHALL stay in REQ.
REQ-018 On WAIT with imem_rvalid=1, the block SHALL load pkt={1, pc, imem_rdata}, set pc to pc+4 (modulo 2^32), and move to FULL.
REQ-019 At most one request SHALL be outstanding; imem_rvalid outside WAIT SHALL be ignored unless a drop is pending (REQ-024).
REQ-020 if_id_d SHALL equal pkt, and if_id_write SHALL equal (pkt[64] & pc_write) | flush.
REQ-021 In FULL with pc_write=1 and flush=0, the packet SHALL be consumed: pkt[64] SHALL clear and the FSM SHALL return to REQ in the same edge.
REQ-022 In FULL with pc_write=0, pkt and pc SHALL hold unchanged, and no request SHALL be issued.
REQ-023 When flush=1 in any state, the block SHALL set pc={br_target[31:2],2'b00}, clear pkt[64], and enter REQ on that edge; if_id_write SHALL be 1 that cycle so a bubble is written.
REQ-024 A flush while in WAIT SHALL set a drop flag; the next imem_rvalid SHALL be discarded and then clear the flag, and no REQ issue SHALL occur until the flag clears.
REQ-025 A flush coincident with imem_rvalid in WAIT SHALL discard that response and SHALL NOT set the drop flag.
REQ-026 flush SHALL take priority over pc_write, and rst SHALL take priority over both.
REQ-027 Fetch-to-packet latency SHALL be 1 cycle after imem_rvalid, and the minimum fetch period SHALL be 3 cycles (REQ, WAIT, FULL) with single-cycle memory.

Reset
REQ-028 While rst=1, the block SHALL set pc=RESET_PC, pkt=65'h0, the drop flag to 0, and the FSM to REQ, immediately and independent of clk.
REQ-029 After rst deasserts, imem_req SHALL be 1, imem_addr SHALL be RESET_PC, and if_id_write SHALL be 0.
REQ-030 A reset asserted during WAIT SHALL abandon the outstanding request, and the first imem_rvalid after reset while in REQ SHALL be ignored.

Verification
REQ-031 Reset release with imem_ready=1 and rvalid one cycle later carrying 32'h0000_0013 -> if_id_d=={1, 32'h0, 32'h13} and if_id_write=1, then imem_addr=32'h4.
REQ-032 Hold pc_write=0 for 5 cycles in FULL -> if_id_d stable, imem_req=0, if_id_write=0; on release -> one write, then the next fetch at pc+4.
REQ-033 flush=1 with br_target=32'h0000_0103 in FULL -> if_id_write=1, if_id_d[64]=0, then next imem_addr=32'h100.
REQ-034 flush during WAIT, then a late rvalid with 32'hDEAD_BEEF -> the word is not written, and the next request goes to the target.
REQ-035 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0 (wrap).
REQ-036 rst pulse asserted mid-WAIT -> all outputs at reset values asynchronously, and the fetch restarts at RESET_PC.
